// File: rtl/gate_input_debounce_pkg.sv
// Shared types and limits for the gate input debouncer.
// The state encoding is visible here so waveform viewers decode it consistently.
package gate_input_debounce_pkg;

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    WAIT_HI = 2'd1,
    ST_HI   = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam int MIN_DEBOUNCE = 2;

endpackage

// File: rtl/debounce_channel.sv
// One channel: synchroniser chain, then a 4-state qualifier with a saturating-free counter.
// GATE_INPUT_DEBOUNCE_EDGE_EN adds registered one-cycle rise/fall pulses.
module debounce_channel
  import gate_input_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic busy
`ifdef GATE_INPUT_DEBOUNCE_EDGE_EN
  ,
  output logic rise_pulse,
  output logic fall_pulse
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state;
  logic [CW-1:0]          cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // level/busy are registered alongside the state so they never glitch on decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_LO;
      cnt   <= '0;
      level <= 1'b0;
      busy  <= 1'b0;
`ifdef GATE_INPUT_DEBOUNCE_EDGE_EN
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
`endif
    end else begin
`ifdef GATE_INPUT_DEBOUNCE_EDGE_EN
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
`endif
      case (state)
        ST_LO: begin
          if (s) begin
            state <= WAIT_HI;
            cnt   <= CW'(1);
            busy  <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        WAIT_HI: begin
          if (!s) begin
            state <= ST_LO;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_HI;
            cnt   <= '0;
            busy  <= 1'b0;
            level <= 1'b1;
`ifdef GATE_INPUT_DEBOUNCE_EDGE_EN
            rise_pulse <= 1'b1;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_HI: begin
          if (!s) begin
            state <= WAIT_LO;
            cnt   <= CW'(1);
            busy  <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        WAIT_LO: begin
          if (s) begin
            state <= ST_HI;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_LO;
            cnt   <= '0;
            busy  <= 1'b0;
            level <= 1'b0;
`ifdef GATE_INPUT_DEBOUNCE_EDGE_EN
            fall_pulse <= 1'b1;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_LO;
          cnt   <= '0;
          busy  <= 1'b0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/gate_input_debounce.sv
// Synchronise and debounce WIDTH raw switch levels into clean gate inputs.
// Optional edge pulses appear when GATE_INPUT_DEBOUNCE_EDGE_EN is defined.
module gate_input_debounce
  import gate_input_debounce_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] busy
`ifdef GATE_INPUT_DEBOUNCE_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
`endif
);

  if (DEBOUNCE_CYCLES < MIN_DEBOUNCE || SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_param_err
    $fatal(1, "gate_input_debounce: DEBOUNCE_CYCLES must be >= 2 and SYNC_STAGES in 2..4");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .raw       (raw_in[i]),
      .level     (level_out[i]),
      .busy      (busy[i])
`ifdef GATE_INPUT_DEBOUNCE_EDGE_EN
      ,
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i])
`endif
    );
  end

endmodule

// File: tb/tb_gate_input_debounce.sv
// Bench for gate_input_debounce: directed scenarios plus random hold-length stimulus,
// checked every cycle against a delay-line + run-length model of the debouncer.
module tb_gate_input_debounce;

  localparam int W = 2;
  localparam int S = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] raw_in = '0;
  logic [W-1:0] level_out;
  logic [W-1:0] busy;
`ifdef GATE_INPUT_DEBOUNCE_EDGE_EN
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  gate_input_debounce #(
    .WIDTH          (W),
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .level_out (level_out),
    .busy      (busy)
`ifdef GATE_INPUT_DEBOUNCE_EDGE_EN
    ,
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
`endif
  );

  // Reference model: raw is seen S edges late; an output flips once the delayed
  // input has disagreed with it for D consecutive samples.
  logic [W-1:0] dly_q[$];
  logic [W-1:0] m_lvl;
  int           m_run[W];
`ifdef GATE_INPUT_DEBOUNCE_EDGE_EN
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;
`endif

  function automatic logic [W-1:0] m_busy();
    logic [W-1:0] b;
    for (int c = 0; c < W; c++) b[c] = (m_run[c] != 0);
    return b;
  endfunction

  function automatic void model_reset();
    dly_q.delete();
    for (int k = 0; k < S; k++) dly_q.push_back('0);
    m_lvl = '0;
    for (int c = 0; c < W; c++) m_run[c] = 0;
`ifdef GATE_INPUT_DEBOUNCE_EDGE_EN
    m_rise = '0;
    m_fall = '0;
`endif
  endfunction

  function automatic void model_edge(input logic [W-1:0] v);
    logic [W-1:0] s;
    s = dly_q.pop_front();
    dly_q.push_back(v);
`ifdef GATE_INPUT_DEBOUNCE_EDGE_EN
    m_rise = '0;
    m_fall = '0;
`endif
    for (int c = 0; c < W; c++) begin
      if (s[c] != m_lvl[c]) begin
        m_run[c]++;
        if (m_run[c] == D) begin
          m_lvl[c] = s[c];
          m_run[c] = 0;
`ifdef GATE_INPUT_DEBOUNCE_EDGE_EN
          m_rise[c] = s[c];
          m_fall[c] = ~s[c];
`endif
        end
      end else begin
        m_run[c] = 0;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".level"}, 32'(level_out), 32'(m_lvl));
    check({tag, ".busy"}, 32'(busy), 32'(m_busy()));
`ifdef GATE_INPUT_DEBOUNCE_EDGE_EN
    check({tag, ".rise"}, 32'(rise_pulse), 32'(m_rise));
    check({tag, ".fall"}, 32'(fall_pulse), 32'(m_fall));
    check({tag, ".both"}, 32'(rise_pulse & fall_pulse), 32'd0);
`endif
  endtask

  task automatic cyc(input logic [W-1:0] v, input string tag);
    @(negedge clk);
    raw_in = v;
    @(posedge clk);
    model_edge(v);
    #1;
    compare_all(tag);
  endtask

  // Reset asserted mid-cycle; outputs must clear with no clock edge.
  task automatic do_reset(input logic [W-1:0] v);
    @(negedge clk);
    raw_in = v;
    #1 rst = 1'b1;
    #1;
    check("rst.level", 32'(level_out), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
`ifdef GATE_INPUT_DEBOUNCE_EDGE_EN
    check("rst.pulses", 32'({rise_pulse, fall_pulse}), 32'd0);
`endif
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk);
    model_edge(v);
    #1;
    compare_all("rst_edge");
  endtask

  // Count edges, from the first one that samples v, until level_out[ch] reaches tgt.
  task automatic latency(input string tag, input logic [W-1:0] v, input int ch,
                         input logic tgt, input int already);
    int n;
    n = already;
    while (level_out[ch] !== tgt && n < 20) begin
      cyc(v, tag);
      n++;
    end
    check(tag, 32'(n), 32'(S + D));
  endtask

  initial begin
    model_reset();
    #2;
    // 1: reset with both inputs high
    do_reset(2'b11);
    repeat (3) cyc(2'b00, "idle");
    repeat (8) cyc(2'b00, "idle");

    // 2: clean rise on bit 0
    latency("lat_rise0", 2'b01, 0, 1'b1, 0);
    repeat (4) cyc(2'b01, "hold");

    // 3: bounce on bit 1 is rejected
    repeat (3) cyc(2'b11, "bounce");
    cyc(2'b01, "bounce");
    repeat (2) cyc(2'b11, "bounce");
    repeat (8) cyc(2'b01, "bounce");
    check("bounce.level1", 32'(level_out[1]), 32'd0);
    check("bounce.busy1", 32'(busy[1]), 32'd0);

    // 4: release of bit 0
    latency("lat_fall0", 2'b00, 0, 1'b0, 0);
    repeat (8) cyc(2'b00, "idle");

    // 5: simultaneous rise, bit 1 bounces once
    cyc(2'b11, "simul");
    cyc(2'b01, "simul");
    repeat (12) cyc(2'b11, "simul");
    check("simul.level", 32'(level_out), 32'd3);
    repeat (10) cyc(2'b00, "idle");

    // 6: reset aborts qualification in progress
    repeat (4) cyc(2'b01, "abort_pre");
    check("abort.busy0", 32'(busy[0]), 32'd1);
    do_reset(2'b01);
    check("abort.level0", 32'(level_out[0]), 32'd0);
    latency("lat_after_rst", 2'b01, 0, 1'b1, 1);

    // Random hold lengths around the debounce window, with occasional resets.
    for (int seg = 0; seg < 400; seg++) begin
      logic [W-1:0] v;
      int           len;
      v   = W'($urandom_range(0, 3));
      len = $urandom_range(1, 2 * D + 1);
      if ($urandom_range(0, 39) == 0) do_reset(v);
      for (int k = 0; k < len; k++) cyc(v, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
